// File: rtl/pipelined_addsub.sv
// pipelined_addsub
// Pipelined WIDTH-bit adder/subtractor. The operation is split into STAGES
// ripple slices of SW = WIDTH/STAGES bits, with one register stage per slice.
// It accepts one operation per cycle under valid/ready flow control.
// Each stage register holds:
//   - the valid bit and the tag,
//   - the result bits computed so far,
//   - the untouched upper slices of X and Y' (Y' = Y or ~Y),
//   - the running carry and a running all-zero flag.
// Bubbles collapse: a stage may load whenever it, or any stage after it,
// holds no valid operation.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready depends on out_ready)
//   X, Y, sub, in_tag   operands, 0:add 1:subtract, pass-through tag
//   out_valid, out_ready output handshake
//   Z, cout, zf, sf, of result and condition codes (cout raw, not inverted)
//   out_tag             tag of the presented result
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = WIDTH / STAGES;

  logic [WIDTH-1:0]  y_eff;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv;

  // Subtraction is X + ~Y + 1; the +1 enters as the carry-in of slice 0.
  assign y_eff = sub ? ~Y : Y;

  // adv[k] = !valid[k] | adv[k+1], unrolled. Stage k may load when any stage
  // from k to the end is empty, or when the consumer takes the result.
  always_comb begin
    logic bubble;
    adv    = '0;
    bubble = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      bubble = bubble | ~valid_q[k];
      adv[k] = bubble | out_ready;
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int RW = (k + 1) * SW;   // result bits known after this stage
    localparam int UW = WIDTH - RW;     // operand bits still to be consumed

    logic [SW-1:0]    a_in;
    logic [SW-1:0]    b_in;
    logic [SW-1:0]    s;
    logic             c_in;
    logic             c_out;
    logic             v_in;
    logic             z_in;
    logic [TAG_W-1:0] tag_in;
    logic [RW-1:0]    res_in;

    logic             v_q;
    logic             c_q;
    logic             z_q;
    logic [TAG_W-1:0] tag_q;
    logic [RW-1:0]    res_q;

    if (k == 0) begin : src
      assign a_in   = X[SW-1:0];
      assign b_in   = y_eff[SW-1:0];
      assign c_in   = sub;
      assign v_in   = in_valid;
      assign z_in   = 1'b1;
      assign tag_in = in_tag;
      assign res_in = s;
    end else begin : src
      assign a_in   = stg[k-1].up.a_q[SW-1:0];
      assign b_in   = stg[k-1].up.b_q[SW-1:0];
      assign c_in   = stg[k-1].c_q;
      assign v_in   = stg[k-1].v_q;
      assign z_in   = stg[k-1].z_q;
      assign tag_in = stg[k-1].tag_q;
      assign res_in = {s, stg[k-1].res_q};
    end

    // Explicit bit-serial ripple across the slice.
    always_comb begin
      logic c;
      s = '0;
      c = c_in;
      for (int i = 0; i < SW; i++) begin
        s[i] = a_in[i] ^ b_in[i] ^ c;
        c    = (a_in[i] & b_in[i]) | (c & (a_in[i] ^ b_in[i]));
      end
      c_out = c;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        z_q   <= 1'b0;
        tag_q <= '0;
        res_q <= '0;
      end else if (adv[k]) begin
        v_q   <= v_in;
        c_q   <= c_out;
        z_q   <= z_in & ~|s;
        tag_q <= tag_in;
        res_q <= res_in;
      end
    end

    assign valid_q[k] = v_q;

    if (UW > 0) begin : up
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;
      logic [UW-1:0] a_nx;
      logic [UW-1:0] b_nx;

      if (k == 0) begin : from_in
        assign a_nx = X[WIDTH-1:SW];
        assign b_nx = y_eff[WIDTH-1:SW];
      end else begin : from_prev
        assign a_nx = stg[k-1].up.a_q[UW+SW-1:SW];
        assign b_nx = stg[k-1].up.b_q[UW+SW-1:SW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k]) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
      end
    end

    if (k == STAGES - 1) begin : lst
      logic of_q;
      // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          of_q <= 1'b0;
        end else if (adv[k]) begin
          of_q <= (a_in[SW-1] ^ b_in[SW-1] ^ s[SW-1]) ^ c_out;
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].v_q;
  assign Z         = stg[STAGES-1].res_q;
  assign cout      = stg[STAGES-1].c_q;
  assign zf        = stg[STAGES-1].z_q;
  assign sf        = stg[STAGES-1].res_q[WIDTH-1];
  assign of        = stg[STAGES-1].lst.of_q;
  assign out_tag   = stg[STAGES-1].tag_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub.
// It drives one 64-bit/4-stage instance and three 8-bit instances with
// STAGES = 1, 2 and 8.
// Results are predicted by plain integer arithmetic at acceptance time and
// queued per instance. They are compared in order when the result retires.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [63:0] z;
    logic        cout;
    logic        zf;
    logic        sf;
    logic        of;
    logic [3:0]  tag;
  } exp_t;

  logic clk;
  logic rst;

  logic        m_in_valid, m_in_ready, m_sub, m_ov, m_or;
  logic        m_cout, m_zf, m_sf, m_of;
  logic [63:0] m_x, m_y, m_z;
  logic [3:0]  m_tag, m_otag;

  logic        s_in_valid, s_sub, s_or;
  logic [7:0]  s_x, s_y;
  logic [3:0]  s_tag;
  logic [2:0]  s_ir, s_ov, s_cout, s_zf, s_sf, s_of;
  logic [7:0]  s_z [3];
  logic [3:0]  s_otag [3];

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt [4];
  exp_t q0[$], q1[$], q2[$], q3[$];

  pipelined_addsub #(.WIDTH(64), .STAGES(4), .TAG_W(4)) dut_main (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .X(m_x), .Y(m_y), .sub(m_sub), .in_tag(m_tag),
    .out_valid(m_ov), .out_ready(m_or), .Z(m_z), .cout(m_cout),
    .zf(m_zf), .sf(m_sf), .of(m_of), .out_tag(m_otag)
  );

  for (genvar g = 0; g < 3; g++) begin : sw
    pipelined_addsub #(.WIDTH(8), .STAGES(g == 0 ? 1 : (g == 1 ? 2 : 8)), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_ir[g]),
      .X(s_x), .Y(s_y), .sub(s_sub), .in_tag(s_tag),
      .out_valid(s_ov[g]), .out_ready(s_or), .Z(s_z[g]), .cout(s_cout[g]),
      .zf(s_zf[g]), .sf(s_sf[g]), .of(s_of[g]), .out_tag(s_otag[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: w-bit add or subtract from plain integer arithmetic.
  function automatic exp_t calc(input logic [63:0] x, input logic [63:0] y,
                                input logic s, input logic [3:0] t, input int w);
    logic [63:0] mask, xm, yp;
    logic [64:0] full;
    exp_t e;
    mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm    = x & mask;
    yp    = (s ? ~y : y) & mask;
    full  = {1'b0, xm} + {1'b0, yp} + {64'd0, s};
    e.z   = full[63:0] & mask;
    e.cout = full[w];
    e.zf  = (e.z == 64'd0);
    e.sf  = e.z[w-1];
    e.of  = (xm[w-1] == yp[w-1]) && (e.z[w-1] != xm[w-1]);
    e.tag = t;
    return e;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut %0d): got 0x%0h, want 0x%0h", name, d, act, exp);
    end
  endtask

  task automatic q_push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic q_clear(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      2: q2.delete();
      default: q3.delete();
    endcase
  endtask

  function automatic int q_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  // Scoreboard. Inputs change just after a rising edge, so the handshakes
  // seen at the falling edge are the ones the next rising edge acts on.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      logic iv, ir, ov, ordy, isb;
      logic [63:0] ix, iy;
      logic [3:0] it;
      int w;
      exp_t got, want;
      bit ok;
      if (d == 0) begin
        iv = m_in_valid; ir = m_in_ready; ov = m_ov; ordy = m_or;
        ix = m_x; iy = m_y; isb = m_sub; it = m_tag; w = 64;
        got.z = m_z; got.cout = m_cout; got.zf = m_zf; got.sf = m_sf;
        got.of = m_of; got.tag = m_otag;
      end else begin
        iv = s_in_valid; ir = s_ir[d-1]; ov = s_ov[d-1]; ordy = s_or;
        ix = {56'd0, s_x}; iy = {56'd0, s_y}; isb = s_sub; it = s_tag; w = 8;
        got.z = {56'd0, s_z[d-1]}; got.cout = s_cout[d-1]; got.zf = s_zf[d-1];
        got.sf = s_sf[d-1]; got.of = s_of[d-1]; got.tag = s_otag[d-1];
      end
      if (rst) begin
        q_clear(d);
      end else begin
        if (ov && ordy) begin
          q_pop(d, want, ok);
          if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_order (dut %0d): got result tag 0x%0h, want no result (none outstanding)", d, got.tag);
          end else begin
            chk("sb_z", d, got.z, want.z);
            chk("sb_cout", d, 64'(got.cout), 64'(want.cout));
            chk("sb_zf", d, 64'(got.zf), 64'(want.zf));
            chk("sb_sf", d, 64'(got.sf), 64'(want.sf));
            chk("sb_of", d, 64'(got.of), 64'(want.of));
            chk("sb_tag", d, 64'(got.tag), 64'(want.tag));
          end
        end
        if (iv && ir) begin
          q_push(d, calc(ix, iy, isb, it, w));
          acc_cnt[d]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [63:0] x, input logic [63:0] y, input logic sb,
                          input logic [3:0] t, output int lat);
    int n;
    m_x = x; m_y = y; m_sub = sb; m_tag = t; m_in_valid = 1'b1;
    n = 0;
    while (!m_in_ready && n < 20) begin step(); n++; end
    step();
    m_in_valid = 1'b0;
    lat = 0;
    while (!m_ov && lat < 20) begin step(); lat++; end
  endtask

  task automatic chk_main(input string name, input logic [63:0] z, input logic c,
                          input logic zfl, input logic sfl, input logic ofl, input logic [3:0] t);
    chk({name, "_z"}, 0, m_z, z);
    chk({name, "_cout"}, 0, 64'(m_cout), 64'(c));
    chk({name, "_zf"}, 0, 64'(m_zf), 64'(zfl));
    chk({name, "_sf"}, 0, 64'(m_sf), 64'(sfl));
    chk({name, "_of"}, 0, 64'(m_of), 64'(ofl));
    chk({name, "_tag"}, 0, 64'(m_otag), 64'(t));
  endtask

  // One op to all 8-bit instances; each result is captured when it appears.
  task automatic sweep_one(input string name, input logic [7:0] x, input logic [7:0] y,
                           input logic sb, input logic [7:0] wz, input logic wof);
    logic [7:0] gz [3];
    logic [2:0] gof, got;
    got = '0; gof = '0;
    for (int g = 0; g < 3; g++) gz[g] = 8'd0;
    s_x = x; s_y = y; s_sub = sb; s_tag = 4'h1; s_or = 1'b1; s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      for (int g = 0; g < 3; g++) begin
        if (s_ov[g] && !got[g]) begin
          gz[g] = s_z[g]; gof[g] = s_of[g]; got[g] = 1'b1;
        end
      end
      step();
    end
    for (int g = 0; g < 3; g++) begin
      chk({name, "_seen"}, g + 1, 64'(got[g]), 64'd1);
      chk({name, "_z"}, g + 1, 64'(gz[g]), 64'(wz));
      chk({name, "_of"}, g + 1, 64'(gof[g]), 64'(wof));
    end
  endtask

  initial begin
    int lat, acc, n, ovc;
    logic ok, ir_drop;
    logic [15:0] ovs;
    exp_t e0;

    for (int d = 0; d < 4; d++) acc_cnt[d] = 0;
    rst = 1'b1;
    m_in_valid = 1'b0; m_x = '0; m_y = '0; m_sub = 1'b0; m_tag = '0; m_or = 1'b1;
    s_in_valid = 1'b0; s_x = '0; s_y = '0; s_sub = 1'b0; s_tag = '0; s_or = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_out_valid", 0, 64'(m_ov), 64'd0);
    chk_main("rst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("rst_in_ready", 0, 64'(m_in_ready), 64'd1);

    // Carry ripples through all four slices.
    send_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'h3, lat);
    chk("add_latency", 0, 64'(lat), 64'd3);
    chk_main("add_wrap", 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
    step();

    send_one(64'h8000_0000_0000_0000, 64'h1, 1'b1, 4'h4, lat);
    chk_main("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4);
    step();

    send_one(64'd5, 64'd7, 1'b1, 4'h5, lat);
    chk_main("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
    step();

    // Back-to-back stream of ten operations.
    ovs = '0; ir_drop = 1'b0; m_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        m_x = 64'h0123_4567_89AB_CDEF * 64'(i + 1);
        m_y = {32'(i), 32'hDEAD_BEEF};
        m_sub = i[0];
        m_tag = 4'(i);
        if (!m_in_ready) ir_drop = 1'b1;
      end else begin
        m_in_valid = 1'b0;
      end
      step();
      ovs[i] = m_ov;
    end
    chk("stream_out_valid", 0, 64'(ovs), 64'h1FF8);
    chk("stream_in_ready_drop", 0, 64'(ir_drop), 64'd0);

    // Stall with a continuous input stream: exactly four fit.
    m_or = 1'b0; m_in_valid = 1'b1; acc = 0;
    for (int c = 0; c < 8; c++) begin
      m_x = 64'(100 + acc); m_y = 64'(7 * acc); m_sub = 1'b0; m_tag = 4'(acc);
      ok = m_in_ready;
      step();
      if (ok) acc++;
    end
    e0 = calc(64'd100, 64'd0, 1'b0, 4'h0, 64);
    chk("stall_accepts", 0, 64'(acc), 64'd4);
    chk("stall_in_ready", 0, 64'(m_in_ready), 64'd0);
    chk("stall_out_valid", 0, 64'(m_ov), 64'd1);
    chk("stall_head_z", 0, m_z, e0.z);
    chk("stall_head_tag", 0, 64'(m_otag), 64'd0);
    m_in_valid = 1'b0; m_or = 1'b1;
    n = 0;
    while (m_ov && n < 10) begin n++; step(); end
    chk("stall_drain_count", 0, 64'(n), 64'd4);
    chk("stall_queue_empty", 0, 64'(q_size(0)), 64'd0);

    // Reset with three operations in flight, plus an op offered during reset.
    m_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_x = 64'(i + 11); m_y = 64'(i + 22); m_sub = 1'b0; m_tag = 4'(i + 8);
      step();
    end
    m_x = 64'hAAAA; m_y = 64'h5555; m_tag = 4'hF;
    rst = 1'b1;
    step();
    rst = 1'b0; m_in_valid = 1'b0;
    chk("mid_rst_out_valid", 0, 64'(m_ov), 64'd0);
    chk_main("mid_rst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    ovc = 0;
    for (int i = 0; i < 5; i++) begin step(); ovc += int'(m_ov); end
    chk("mid_rst_no_stale", 0, 64'(ovc), 64'd0);
    send_one(64'd1, 64'd2, 1'b0, 4'h5, lat);
    chk("post_rst_latency", 0, 64'(lat), 64'd3);
    chk_main("post_rst", 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
    step();

    // 8-bit instances: slice-boundary carries, then random traffic.
    sweep_one("carry_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    sweep_one("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
    sweep_one("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);

    for (int c = 0; c < 6000; c++) begin
      if (acc_cnt[1] >= 1003 && acc_cnt[2] >= 1003 && acc_cnt[3] >= 1003) break;
      s_in_valid = ($urandom_range(0, 3) != 0);
      s_x   = 8'($urandom);
      s_y   = 8'($urandom);
      s_sub = 1'($urandom_range(0, 1));
      s_tag = 4'($urandom);
      s_or  = ($urandom_range(0, 9) < 6);
      step();
    end
    s_in_valid = 1'b0; s_or = 1'b1;
    repeat (12) step();
    for (int d = 1; d < 4; d++) begin
      chk("sweep_ops_done", d, 64'(acc_cnt[d] >= 1003), 64'd1);
      chk("sweep_queue_empty", d, 64'(q_size(d)), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
